// File: rtl/seq_mult_unit_if.sv
// ----------------------------------------------------------------------------
// seq_mult_unit_if
//   Request/response bundle between the core (master) and the sequential
//   multiplier (slave).
//   master drives : start, is_signed, abort, a, b
//   slave drives  : busy, done, hi, lo
// ----------------------------------------------------------------------------
interface seq_mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, abort, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, abort, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/seq_mult_unit.sv
// ----------------------------------------------------------------------------
// seq_mult_unit
//   Multi-cycle signed/unsigned multiplier for MULT/MULTU. Operates on operand
//   magnitudes, retiring BPC multiplier bits per clock, and applies the sign to
//   the final 2*WIDTH-bit product. The result is held until the next one
//   completes.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   mif    : slave side of seq_mult_unit_if
//            (start/is_signed/abort/a/b in, busy/done/hi/lo out)
// ----------------------------------------------------------------------------
module seq_mult_unit #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic           clk,
    input  logic           reset,
    seq_mult_unit_if.slave mif
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    mcand_q;   // multiplicand, pre-shifted to the current digit position
    logic [WIDTH-1:0] mplier_q;  // remaining multiplier digits, low digit first
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    res_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_mag, b_mag;

    // A new request is taken only outside RUN; abort blocks it.
    assign accept = (state_q != RUN) && mif.start && !mif.abort;
    assign last   = (cnt_q == CW'(1));

    // The most-negative operand negates to itself, which read unsigned is
    // exactly 2^(WIDTH-1), so no extra magnitude bit is needed.
    assign a_mag = (mif.is_signed && mif.a[WIDTH-1]) ? (~mif.a + WIDTH'(1)) : mif.a;
    assign b_mag = (mif.is_signed && mif.b[WIDTH-1]) ? (~mif.b + WIDTH'(1)) : mif.b;

    // Partial product never exceeds PW bits because the full product fits.
    assign pp    = mcand_q * {{(PW-BPC){1'b0}}, mplier_q[BPC-1:0]};
    assign acc_d = acc_q + pp;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN: begin
                if (mif.abort) state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mif.busy = (state_q == RUN);
        mif.done = (state_q == DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else if (accept) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            acc_q    <= '0;
            cnt_q    <= CW'(N);
            neg_q    <= mif.is_signed && (mif.a[WIDTH-1] ^ mif.b[WIDTH-1]);
        end else if (state_q == RUN && !mif.abort) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << BPC;
            mplier_q <= mplier_q >> BPC;
            cnt_q    <= cnt_q - CW'(1);
            // Result register only moves on the edge that enters DONE.
            if (last) res_q <= neg_q ? (~acc_d + PW'(1)) : acc_d;
        end
    end

    assign mif.hi = res_q[PW-1:WIDTH];
    assign mif.lo = res_q[WIDTH-1:0];
endmodule

// File: tb/tb_seq_mult_unit.sv
module tb_seq_mult_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_mult_unit_if #(.WIDTH(32)) m1 ();
    seq_mult_unit_if #(.WIDTH(32)) m2 ();
    seq_mult_unit_if #(.WIDTH(32)) m4 ();

    seq_mult_unit #(.WIDTH(32), .BPC(1)) u1 (.clk(clk), .reset(reset), .mif(m1));
    seq_mult_unit #(.WIDTH(32), .BPC(2)) u2 (.clk(clk), .reset(reset), .mif(m2));
    seq_mult_unit #(.WIDTH(32), .BPC(4)) u4 (.clk(clk), .reset(reset), .mif(m4));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer product of the operands as the ISA defines them.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input logic st, input logic ab, input logic s,
                             input logic [31:0] a, input logic [31:0] b);
        m1.start = st; m1.abort = ab; m1.is_signed = s; m1.a = a; m1.b = b;
        m2.start = st; m2.abort = ab; m2.is_signed = s; m2.a = a; m2.b = b;
        m4.start = st; m4.abort = ab; m4.is_signed = s; m4.a = a; m4.b = b;
    endtask

    // One operation on all three DUTs; checks latency, single done, result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input string nm);
        int d1, d2, d4, n1, n2, n4, both;
        d1 = 0; d2 = 0; d4 = 0; n1 = 0; n2 = 0; n4 = 0; both = 0;
        drive_all(1'b1, 1'b0, s, a, b);
        step();
        // operands are free to change once accepted
        drive_all(1'b0, 1'b0, 1'($urandom), $urandom, $urandom);
        for (int c = 1; c <= 40; c++) begin
            step();
            if (m1.done) begin n1++; if (d1 == 0) d1 = c; end
            if (m2.done) begin n2++; if (d2 == 0) d2 = c; end
            if (m4.done) begin n4++; if (d4 == 0) d4 = c; end
            if ((m1.busy && m1.done) || (m2.busy && m2.done) || (m4.busy && m4.done)) both++;
        end
        chk({nm, " lat bpc1"}, d1, 32);
        chk({nm, " lat bpc2"}, d2, 16);
        chk({nm, " lat bpc4"}, d4, 8);
        chk({nm, " ndone bpc1"}, n1, 1);
        chk({nm, " ndone bpc2"}, n2, 1);
        chk({nm, " ndone bpc4"}, n4, 1);
        chk({nm, " busy&done"}, both, 0);
        chk({nm, " res bpc1"}, {m1.hi, m1.lo}, exp);
        chk({nm, " res bpc2"}, {m2.hi, m2.lo}, exp);
        chk({nm, " res bpc4"}, {m4.hi, m4.lo}, exp);
    endtask

    vec_t tbl[7];

    initial begin : main
        int d1, n1;
        int dq[$];
        logic [31:0] ra, rb;
        logic        rs;

        tbl[0] = '{32'd7,         32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
        tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[5] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h0000_0000};
        tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000};

        reset = 1'b1;
        drive_all(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(); step();
        chk("reset busy", m1.busy, 0);
        chk("reset done", m1.done, 0);
        chk("reset hilo", {m1.hi, m1.lo}, 64'h0);
        reset = 1'b0;
        step();
        chk("idle busy", m1.busy, 0);

        // table vectors
        for (int i = 0; i < 7; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, {tbl[i].hi, tbl[i].lo}, $sformatf("vec%0d", i));

        // start while busy is ignored
        drive_all(1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD);
        step();
        d1 = 0; n1 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) drive_all(1'b1, 1'b0, 1'b0, 32'd100, 32'd100);
            else        drive_all(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            step();
            if (m1.done) begin n1++; if (d1 == 0) d1 = c; end
        end
        chk("busystart lat", d1, 32);
        chk("busystart ndone", n1, 1);
        chk("busystart res", {m1.hi, m1.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // abort at cycle 10 of RUN
        drive_all(1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
        step();
        drive_all(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int c = 1; c <= 9; c++) step();
        drive_all(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        step();
        drive_all(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("abort busy", m1.busy, 0);
        chk("abort done", m1.done, 0);
        chk("abort hold", {m1.hi, m1.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        n1 = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (m1.done) n1++;
        end
        chk("abort nodone", n1, 0);

        // abort and start together while idle: start dropped
        drive_all(1'b1, 1'b1, 1'b0, 32'd2, 32'd3);
        step();
        chk("abort+start busy", m1.busy, 0);
        drive_all(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        chk("abort+start done", m1.done, 0);
        chk("abort+start hold", {m1.hi, m1.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // reset mid-RUN
        drive_all(1'b1, 1'b0, 1'b0, 32'd9, 32'd9);
        step();
        drive_all(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int c = 0; c < 5; c++) step();
        reset = 1'b1;
        step();
        chk("rstrun busy", m1.busy, 0);
        chk("rstrun done", m1.done, 0);
        chk("rstrun hilo", {m1.hi, m1.lo}, 64'h0);
        reset = 1'b0;
        step();
        chk("rstrun idle", m1.busy, 0);

        // start held high: back-to-back operations every N+1 cycles
        drive_all(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd3);
        for (int c = 1; c <= 110; c++) begin
            step();
            if (m1.done) begin
                dq.push_back(c);
                chk($sformatf("b2b res@%0d", c), {m1.hi, m1.lo}, 64'hFFFF_FFFF_FFFF_FFD0);
            end
        end
        chk("b2b ndone", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("b2b first", dq[0], 33);
            chk("b2b gap0", dq[1] - dq[0], 33);
            chk("b2b gap1", dq[2] - dq[1], 33);
        end
        drive_all(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int c = 0; c < 45; c++) step();

        // random signed/unsigned sweep on all three digit widths
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            if (i % 6 == 1) ra = 32'h8000_0000;
            if (i % 6 == 2) rb = 32'h0;
            run_op(ra, rb, rs, ref_mul(ra, rb, rs), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
